// File: rtl/dsi_lanes_distributor.sv
// Spreads the 32-bit packet word stream round-robin over up to four lane FIFOs.
// Bytes are compacted by strobe, buffered, then written as wide as the lane window allows.
module dsi_lanes_distributor #(
  parameter int LANES_MAX = 4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [31:0] iface_write_data,
  input  logic [3:0]  iface_write_strb,
  input  logic        iface_write_rqst,
  input  logic        iface_last_word,
  output logic        iface_data_rqst,
  input  logic [1:0]  reg_lanes_number,
  output logic [35:0] wr_fifo_data,
  output logic [3:0]  wr_fifo_write,
  input  logic [3:0]  wr_fifo_full,
  output logic        packet_active,
  output logic        err_strb,
  output logic [15:0] bytes_sent
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state, state_next;
  logic [3:0][7:0] hold;
  logic [2:0]      count;
  logic            pend_last;
  logic [1:0]      lane_ptr;
  logic [1:0]      n_lat;
  logic            ready_en;

  logic [2:0]      lanes, rem, m, ptr_sum;
  logic [3:0]      target;
  logic [3:0]      flag;
  logic            stall, do_write, drain_all;
  logic            accept, strb_zero, tail_flag, last_write, close_empty, err_next;
  logic [3:0][7:0] comp;
  logic [3:0][7:0] shifted;
  logic [2:0]      ccount;
  logic [1:0]      lane_ptr_next;

  // Write window: how many buffered bytes fit before the lane pointer wraps.
  always_comb begin
    lanes    = {1'b0, n_lat} + 3'd1;
    rem      = lanes - {1'b0, lane_ptr};
    m        = (count < rem) ? count : rem;
    target   = '0;
    flag     = '0;
    for (int i = 0; i < LANES_MAX; i++) begin
      target[i] = (3'(i) >= {1'b0, lane_ptr}) && (3'(i) < ({1'b0, lane_ptr} + m));
      flag[i]   = (3'(i) == ({1'b0, lane_ptr} + m - 3'd1));
    end
    stall     = |(target & wr_fifo_full);
    do_write  = (count != 3'd0) && !stall;
    drain_all = do_write && (m == count);

    iface_data_rqst = ready_en && ((count == 3'd0) || (drain_all && !pend_last));
    accept          = iface_write_rqst && iface_data_rqst;
    strb_zero       = (iface_write_strb == 4'd0);
    // An empty-strobe last word landing on a draining buffer tags the byte going out now.
    tail_flag       = accept && strb_zero && iface_last_word && (count != 3'd0);
    last_write      = drain_all && (pend_last || tail_flag);
    close_empty     = accept && strb_zero && iface_last_word && (count == 3'd0);
    err_next        = accept && strb_zero && !tail_flag;

    ptr_sum = {1'b0, lane_ptr} + m;
    if (last_write || close_empty)
      lane_ptr_next = 2'd0;
    else if (do_write)
      lane_ptr_next = (ptr_sum == lanes) ? 2'd0 : ptr_sum[1:0];
    else
      lane_ptr_next = lane_ptr;

    shifted = hold >> {m, 3'b000};
  end

  // Strobe compaction in ascending byte order.
  always_comb begin
    comp   = '0;
    ccount = 3'd0;
    for (int b = 0; b < 4; b++) begin
      if (iface_write_strb[b]) begin
        comp[ccount[1:0]] = iface_write_data[b*8 +: 8];
        ccount            = ccount + 3'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (last_write || close_empty)
      state_next = IDLE;
    else if (accept && (state == IDLE))
      state_next = ACTIVE;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold          <= '0;
      count         <= 3'd0;
      pend_last     <= 1'b0;
      lane_ptr      <= 2'd0;
      n_lat         <= 2'd0;
      ready_en      <= 1'b0;
      wr_fifo_write <= 4'd0;
      wr_fifo_data  <= 36'd0;
      err_strb      <= 1'b0;
      bytes_sent    <= 16'd0;
    end else begin
      ready_en      <= 1'b1;
      state         <= state_next;
      err_strb      <= err_next;
      lane_ptr      <= lane_ptr_next;
      wr_fifo_write <= do_write ? target : 4'd0;

      for (int i = 0; i < LANES_MAX; i++) begin
        if (do_write && target[i])
          wr_fifo_data[i*9 +: 9] <= {last_write && flag[i], hold[2'(i) - lane_ptr]};
      end

      if (accept && !strb_zero) begin
        hold      <= comp;
        count     <= ccount;
        pend_last <= iface_last_word;
      end else if (accept) begin
        hold      <= shifted;
        count     <= 3'd0;
        pend_last <= 1'b0;
      end else if (do_write) begin
        hold  <= shifted;
        count <= count - m;
        if (last_write)
          pend_last <= 1'b0;
      end

      if (accept && (state == IDLE)) begin
        n_lat      <= reg_lanes_number;
        bytes_sent <= 16'd0;
      end else if (do_write) begin
        bytes_sent <= ({1'b0, bytes_sent} + {14'd0, m} > 17'h0FFFF) ? 16'hFFFF
                                                                     : bytes_sent + {13'd0, m};
      end
    end
  end

  assign packet_active = (state != IDLE);

endmodule
